// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and the buffered response record.
// Pure type/constant package; no logic, no latency.
// No flow control here; consumers apply their own handshakes.
package alu_pkg;

  localparam int XLEN    = 64;
  // Widest requester tag any arbiter built on this package carries (8 requesters).
  localparam int IDW_MAX = 3;

  typedef enum logic [3:0] {
    AND = 4'd0,
    OR  = 4'd1,
    ADD = 4'd2,
    SUB = 4'd6,
    SLT = 4'd7,
    NOR = 4'd12
  } alu_op_e;

  typedef struct packed {
    logic [IDW_MAX-1:0] id;
    logic [XLEN-1:0]    y;
    logic               zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NREQ.
// Purely combinational, zero latency.
// No backpressure of its own; the caller qualifies the grant with its accept condition.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            any
);

  // Scan from the pointer; the first hit wins and later hits are ignored.
  always_comb begin : pick_comb
    int j;
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'((32'(ptr) + 32'(k)) % 32'(NREQ));
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        gidx     = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one integer ALU among NREQ valid/ready requesters with round-robin arbitration.
// Latency: accept in cycle N gives rsp_valid in cycle N+1; one op per cycle when rsp_ready stays high.
// Backpressure: while the single-entry buffer is full and rsp_ready is low, every req_ready is held low.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = XLEN,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][3:0]       req_ctrl,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_y,
  output logic                       rsp_zero
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt, gidx;
  logic [NREQ-1:0]  grant;
  logic             any, can_accept, accept;
  logic [3:0]       op;
  logic [WIDTH-1:0] op_a, op_b, alu_y;
  alu_rsp_t         rsp_q;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  // Only the granted requester's operands reach the ALU.
  assign op      = req_ctrl[gidx];
  assign op_a    = req_a[gidx];
  assign op_b    = req_b[gidx];
  assign ptr_nxt = IDW'((32'(gidx) + 32'd1) % 32'(NREQ));

  // ALU function; undefined codes produce zero.
  always_comb begin
    alu_y = '0;
    case (alu_op_e'(op))
      AND:     alu_y = op_a & op_b;
      OR:      alu_y = op_a | op_b;
      ADD:     alu_y = op_a + op_b;
      SUB:     alu_y = op_a - op_b;
      SLT:     alu_y = (op_a < op_b) ? WIDTH'(1) : '0;
      NOR:     alu_y = ~(op_a | op_b);
      default: alu_y = '0;
    endcase
  end

  // Next state and handshake outputs; a drain and a new accept may share a cycle.
  always_comb begin
    state_nxt  = state;
    rsp_valid  = (state == FULL);
    can_accept = (state == EMPTY) || (rsp_valid && rsp_ready);
    accept     = any && can_accept && !reset;
    req_ready  = accept ? grant : '0;
    if (accept) begin
      state_nxt = FULL;
    end else if (rsp_valid && rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Response buffer and priority pointer move only on an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q <= '0;
      ptr   <= '0;
    end else if (accept) begin
      rsp_q.id   <= IDW_MAX'(gidx);
      rsp_q.y    <= XLEN'(alu_y);
      rsp_q.zero <= (alu_y == '0);
      ptr        <= ptr_nxt;
    end
  end

  assign rsp_id   = rsp_q.id[IDW-1:0];
  assign rsp_y    = rsp_q.y[WIDTH-1:0];
  assign rsp_zero = rsp_q.zero;

  // Tag/result bits above IDW/WIDTH are always loaded as zero.
  logic unused_bits;
  assign unused_bits = ^{rsp_q.id, rsp_q.y};

  // Requesters must keep valid and payload steady until they are granted.
  for (genvar i = 0; i < NREQ; i++) begin : g_proto
    a_req_hold: assert property (@(posedge clk)
      (!reset && req_valid[i] && !req_ready[i]) |=>
        (reset || (req_valid[i] && $stable(req_ctrl[i]) &&
                   $stable(req_a[i]) && $stable(req_b[i]))));
  end

  a_one_ready: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with three requesters.
// Spec-level model (queue-free single-slot buffer, scan-from-pointer arbitration) checked every cycle.
// Directed table, multi-cycle corner sequences and a randomized run share that model.
module tb_alu_share_arb;

  localparam int N  = 3;
  localparam int W  = 64;
  localparam int IW = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0]           req_valid, req_ready;
  logic [N-1:0][3:0]      req_ctrl;
  logic [N-1:0][W-1:0]    req_a, req_b;
  logic                   rsp_valid, rsp_ready, rsp_zero;
  logic [IW-1:0]          rsp_id;
  logic [W-1:0]           rsp_y;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state: what the consumer should see, plus the priority pointer.
  bit          m_known = 1'b0;
  bit          m_valid = 1'b0;
  int          m_id = 0;
  logic [W-1:0] m_y = '0;
  bit          m_zero = 1'b0;
  int          m_p = 0;
  int          wait_acc [N];
  int          fire_idx = -1;

  function automatic logic [W-1:0] alu_ref(int c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      0:       return a & b;
      1:       return a | b;
      2:       return a + b;
      6:       return a - b;
      7:       return (a < b) ? W'(1) : W'(0);
      12:      return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    int           w;
    bit           can;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] y_new;
    @(negedge clk);
    if (m_known) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("rsp_id",    64'(rsp_id),    64'(m_id));
      chk("rsp_y",     rsp_y,          m_y);
      chk("rsp_zero",  64'(rsp_zero),  64'(m_zero));
    end
    can = (!m_valid || rsp_ready) && !reset;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_p + k) % N;
      if (w < 0 && req_valid[j]) w = j;
    end
    exp_rdy = '0;
    if (can && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    fire_idx = (can && w >= 0) ? w : -1;
    y_new = '0;
    if (fire_idx >= 0) y_new = alu_ref(int'(req_ctrl[w]), req_a[w], req_b[w]);
    @(posedge clk);
    if (reset) begin
      m_known = 1'b1;
      m_valid = 1'b0; m_id = 0; m_y = '0; m_zero = 1'b0; m_p = 0;
      for (int i = 0; i < N; i++) wait_acc[i] = 0;
      fire_idx = -1;
    end else if (fire_idx >= 0) begin
      for (int i = 0; i < N; i++) begin
        if (i == fire_idx) begin
          chk("no_starve", 64'(wait_acc[i] < N), 64'(1));
          wait_acc[i] = 0;
        end else if (req_valid[i]) begin
          wait_acc[i]++;
        end
      end
      m_valid = 1'b1; m_id = fire_idx; m_y = y_new; m_zero = (y_new == '0);
      m_p = (fire_idx + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    cycle();
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    cycle();
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b1;
  endtask

  function automatic logic [3:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd2;
      3:       return 4'd6;
      4:       return 4'd7;
      5:       return 4'd12;
      6:       return 4'd5;
      default: return 4'd15;
    endcase
  endfunction

  task automatic new_payload(int i);
    req_ctrl[i] = rnd_op();
    req_a[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : {$urandom, $urandom};
    req_b[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) req_b[i] = req_a[i];
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [63:0] a, b, y;
    logic        z;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int n_acc;
    int served;

    tbl[0]  = '{4'd2,  64'd5,                  64'd7,      64'd12,                 1'b0};
    tbl[1]  = '{4'd0,  64'hF0F0,               64'h0FF0,   64'h00F0,               1'b0};
    tbl[2]  = '{4'd1,  64'hF0F0,               64'h0FF0,   64'hFFF0,               1'b0};
    tbl[3]  = '{4'd12, 64'hF0F0,               64'h0FF0,   64'hFFFF_FFFF_FFFF_000F, 1'b0};
    tbl[4]  = '{4'd5,  64'hF0F0,               64'h0FF0,   64'h0,                  1'b1};
    tbl[5]  = '{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,     64'h0,                  1'b1};
    tbl[6]  = '{4'd6,  64'd9,                  64'd9,      64'h0,                  1'b1};
    tbl[7]  = '{4'd6,  64'd0,                  64'd1,      64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[8]  = '{4'd7,  64'd3,                  64'd4,      64'd1,                  1'b0};
    tbl[9]  = '{4'd7,  64'h8000_0000_0000_0000, 64'd1,     64'd0,                  1'b1};
    tbl[10] = '{4'd15, 64'd3,                  64'd4,      64'd0,                  1'b1};

    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_ctrl = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) wait_acc[i] = 0;

    // Reset values.
    do_reset();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id",    64'(rsp_id),    64'(0));
    chk("rst_rsp_y",     rsp_y,          64'(0));
    chk("rst_rsp_zero",  64'(rsp_zero),  64'(0));

    // Opcode table through requester 0, back to back.
    for (int i = 0; i < 11; i++) begin
      req_valid = 3'b001; rsp_ready = 1'b1;
      req_ctrl[0] = tbl[i].ctrl; req_a[0] = tbl[i].a; req_b[0] = tbl[i].b;
      cycle();
      req_valid = '0;
      chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'(1));
      chk($sformatf("tbl%0d_id", i),    64'(rsp_id),    64'(0));
      chk($sformatf("tbl%0d_y", i),     rsp_y,          tbl[i].y);
      chk($sformatf("tbl%0d_zero", i),  64'(rsp_zero),  64'(tbl[i].z));
    end
    cycle();
    chk("drain_valid", 64'(rsp_valid), 64'(0));
    chk("drain_y_hold", rsp_y, tbl[10].y);

    // Contention 0/1: grants alternate with no bubbles.
    do_reset();
    req_ctrl[0] = 4'd6; req_a[0] = 64'd9; req_b[0] = 64'd9;
    req_ctrl[1] = 4'd7; req_a[1] = 64'd3; req_b[1] = 64'd4;
    req_valid = 3'b011; rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("cont_valid", 64'(rsp_valid), 64'(1));
      chk("cont_id",    64'(rsp_id),    64'(k % 2));
      chk("cont_y",     rsp_y,          64'(k % 2));
      chk("cont_zero",  64'(rsp_zero),  64'((k % 2) == 0));
    end

    // Backpressure: buffer holds req 0's result, nothing granted.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'(0));
      cycle();
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_id",    64'(rsp_id),    64'(0));
      chk("bp_y",     rsp_y,          64'(0));
      chk("bp_zero",  64'(rsp_zero),  64'(1));
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'(3'b010));
    cycle();
    chk("bp_release_valid", 64'(rsp_valid), 64'(1));
    chk("bp_release_id",    64'(rsp_id),    64'(1));
    chk("bp_release_y",     rsp_y,          64'(1));

    // Reset while full discards the result and clears the pointer.
    rsp_ready = 1'b0;
    cycle();
    do_reset();
    chk("rstfull_valid", 64'(rsp_valid), 64'(0));
    req_valid = 3'b011;
    #1;
    chk("ptr_reset_ready", 64'(req_ready), 64'(3'b001));
    cycle();
    chk("ptr_reset_id", 64'(rsp_id), 64'(0));

    // Requester 2 held while 0/1 toggle: served within N accepts.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_ctrl[i] = 4'd2; req_a[i] = W'(i); req_b[i] = 64'd1;
    end
    req_valid = 3'b111;
    n_acc = 0; served = -1;
    for (int s = 0; s < 6; s++) begin
      logic [N-1:0] fired;
      #1;
      fired = req_ready & req_valid;
      if (fired[2] && served < 0) served = n_acc;
      if (fired != '0) n_acc++;
      cycle();
      for (int j = 0; j < 2; j++) begin
        if (fired[j]) req_valid[j] = 1'b0;
        else if (!req_valid[j]) req_valid[j] = 1'b1;
      end
      if (fired[2]) req_valid[2] = 1'b0;
    end
    chk("fair_req2_served", 64'(served >= 0 && served < N), 64'(1));

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && fire_idx == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          new_payload(i);
        end else if (!req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          new_payload(i);
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
